// File: rtl/pixel_scan_counter.sv
// Raster position generator: column/row tracking over a programmable frame with row/frame events.
// Define PIXEL_SCAN_SERPENTINE_EN to honour the serpentine input (odd rows scanned right-to-left).
module pixel_scan_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [CNT_BITS-1:0] n_columns,
    input  logic [CNT_BITS-1:0] n_rows,
    input  logic                serpentine,
    input  logic                count_enable,
    input  logic                flag_clear,
    output logic                busy,
    output logic [CNT_BITS-1:0] col_count_out,
    output logic [CNT_BITS-1:0] row_count_out,
    output logic                last_pixel,
    output logic                switch_rows,
    output logic                image_done_flag
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_BITS-1:0] cols_r, cols_s;
    logic [CNT_BITS-1:0] rows_r, rows_s;
    logic [CNT_BITS-1:0] col_r, col_s;
    logic [CNT_BITS-1:0] row_r, row_s;
    logic                switch_r, switch_s;
    logic                flag_r, flag_s;
    logic [CNT_BITS-1:0] last_col_s;
    logic [CNT_BITS-1:0] last_row_s;
    logic                rev_row_s;
    logic                next_rev_s;
    logic                row_end_s;
    logic                at_last_row_s;
    logic                size_zero_s;
    logic                flag_hold_s;
    logic                last_pixel_s;

`ifdef PIXEL_SCAN_SERPENTINE_EN
    logic serp_r, serp_s;

    // Odd rows run backwards; next_rev_s describes the row about to be entered.
    assign rev_row_s  = serp_r & row_r[0];
    assign next_rev_s = serp_r & ~row_r[0];
`else
    logic unused_serp_s;

    assign unused_serp_s = serpentine;
    assign rev_row_s     = 1'b0;
    assign next_rev_s    = 1'b0;
`endif

    assign last_col_s    = cols_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
    assign last_row_s    = rows_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
    assign row_end_s     = rev_row_s ? (col_r == {CNT_BITS{1'b0}}) : (col_r == last_col_s);
    assign at_last_row_s = (row_r == last_row_s);
    assign size_zero_s   = (n_columns == {CNT_BITS{1'b0}}) || (n_rows == {CNT_BITS{1'b0}});
    assign flag_hold_s   = flag_clear ? 1'b0 : flag_r;
    assign last_pixel_s  = (state_r == ST_SCAN) && row_end_s && at_last_row_s;

    // Next-state, next-count and event logic.
    always_comb begin
        state_s  = state_r;
        cols_s   = cols_r;
        rows_s   = rows_r;
        col_s    = col_r;
        row_s    = row_r;
        switch_s = 1'b0;
        flag_s   = flag_hold_s;
`ifdef PIXEL_SCAN_SERPENTINE_EN
        serp_s   = serp_r;
`endif
        if (start) begin
            // Accepted in either state; a restart during SCAN leaves the flag alone.
            cols_s = n_columns;
            rows_s = n_rows;
            col_s  = {CNT_BITS{1'b0}};
            row_s  = {CNT_BITS{1'b0}};
`ifdef PIXEL_SCAN_SERPENTINE_EN
            serp_s = serpentine;
`endif
            if (size_zero_s) begin
                state_s = ST_IDLE;
                flag_s  = 1'b1;
            end else begin
                state_s = ST_SCAN;
                flag_s  = (state_r == ST_IDLE) ? 1'b0 : flag_hold_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SCAN: begin
                    if (!count_enable) begin
                        state_s = ST_SCAN;
                    end else if (last_pixel_s) begin
                        state_s  = ST_IDLE;
                        col_s    = {CNT_BITS{1'b0}};
                        row_s    = {CNT_BITS{1'b0}};
                        switch_s = 1'b1;
                        flag_s   = 1'b1;
                    end else if (row_end_s) begin
                        row_s    = row_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
                        col_s    = next_rev_s ? last_col_s : {CNT_BITS{1'b0}};
                        switch_s = 1'b1;
                    end else begin
                        col_s = rev_row_s ? (col_r - {{(CNT_BITS-1){1'b0}}, 1'b1})
                                          : (col_r + {{(CNT_BITS-1){1'b0}}, 1'b1});
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    col_s   = {CNT_BITS{1'b0}};
                    row_s   = {CNT_BITS{1'b0}};
                end
            endcase
        end
    end

    // State, count and event registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= ST_IDLE;
            cols_r   <= {CNT_BITS{1'b0}};
            rows_r   <= {CNT_BITS{1'b0}};
            col_r    <= {CNT_BITS{1'b0}};
            row_r    <= {CNT_BITS{1'b0}};
            switch_r <= 1'b0;
            flag_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cols_r   <= cols_s;
            rows_r   <= rows_s;
            col_r    <= col_s;
            row_r    <= row_s;
            switch_r <= switch_s;
            flag_r   <= flag_s;
        end
    end

`ifdef PIXEL_SCAN_SERPENTINE_EN
    // Scan-order register, latched with the sizes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            serp_r <= 1'b0;
        end else begin
            serp_r <= serp_s;
        end
    end
`endif

    assign busy            = (state_r == ST_SCAN);
    assign col_count_out   = col_r;
    assign row_count_out   = row_r;
    assign last_pixel      = last_pixel_s;
    assign switch_rows     = switch_r;
    assign image_done_flag = flag_r;

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Randomized scoreboard bench for pixel_scan_counter against a pixel-ordinal reference model.
module tb_pixel_scan_counter;

    localparam int W = 16;
`ifdef PIXEL_SCAN_SERPENTINE_EN
    localparam bit SERP_EN = 1'b1;
`else
    localparam bit SERP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [W-1:0] n_columns;
    logic [W-1:0] n_rows;
    logic         serpentine;
    logic         count_enable;
    logic         flag_clear;
    logic         busy;
    logic [W-1:0] col_count_out;
    logic [W-1:0] row_count_out;
    logic         last_pixel;
    logic         switch_rows;
    logic         image_done_flag;

    pixel_scan_counter #(.CNT_BITS(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .n_columns(n_columns), .n_rows(n_rows),
        .serpentine(serpentine), .count_enable(count_enable), .flag_clear(flag_clear),
        .busy(busy), .col_count_out(col_count_out), .row_count_out(row_count_out),
        .last_pixel(last_pixel), .switch_rows(switch_rows), .image_done_flag(image_done_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         busy;
        logic [W-1:0] col;
        logic [W-1:0] row;
        logic         last;
        logic         sw;
        logic         flag;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e;
    int    total = 0;
    int    bad   = 0;

    // Reference model: position is a pixel ordinal within the frame.
    bit     m_busy, m_serp, m_flag, m_sw;
    longint m_nc, m_nr, m_p;

    function automatic snap_t expect_now();
        snap_t  s;
        longint r, k;
        s.busy = m_busy;
        s.sw   = m_sw;
        s.flag = m_flag;
        s.col  = '0;
        s.row  = '0;
        s.last = 1'b0;
        if (m_busy) begin
            r = m_p / m_nc;
            k = m_p % m_nc;
            s.row  = W'(r);
            s.col  = (SERP_EN && m_serp && (r % 2 == 1)) ? W'(m_nc - 1 - k) : W'(k);
            s.last = (m_p == m_nc * m_nr - 1);
        end
        return s;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_serp = 0; m_flag = 0; m_sw = 0;
        m_nc = 0; m_nr = 0; m_p = 0;
    endfunction

    task automatic cycle(input bit st, input int nc, input int nr, input bit sp,
                         input bit ce, input bit fc);
        bit was_busy;
        start = st; n_columns = W'(nc); n_rows = W'(nr);
        serpentine = sp; count_enable = ce; flag_clear = fc;
        was_busy = m_busy;
        m_sw = 0;
        if (st) begin
            m_nc = nc; m_nr = nr; m_serp = sp; m_p = 0;
            if (nc == 0 || nr == 0) begin
                m_busy = 0;
                m_flag = 1;
            end else begin
                m_busy = 1;
                m_flag = was_busy ? (fc ? 1'b0 : m_flag) : 1'b0;
            end
        end else if (m_busy && ce) begin
            m_flag = fc ? 1'b0 : m_flag;
            if ((m_p + 1) % m_nc == 0) m_sw = 1;
            if (m_p == m_nc * m_nr - 1) begin
                m_busy = 0;
                m_p    = 0;
                m_flag = 1;
            end else begin
                m_p = m_p + 1;
            end
        end else begin
            m_flag = fc ? 1'b0 : m_flag;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(expect_now());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run(input int n, input bit ce);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, ce, 0);
    endtask

    // Monitor: one expected snapshot per clock, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (busy !== mon_e.busy || col_count_out !== mon_e.col || row_count_out !== mon_e.row ||
                last_pixel !== mon_e.last || switch_rows !== mon_e.sw || image_done_flag !== mon_e.flag) begin
                bad++;
                $display("FAIL scan t=%0t got busy=%0b col=%0d row=%0d last=%0b sw=%0b flag=%0b want busy=%0b col=%0d row=%0d last=%0b sw=%0b flag=%0b",
                         $time, busy, col_count_out, row_count_out, last_pixel, switch_rows, image_done_flag,
                         mon_e.busy, mon_e.col, mon_e.row, mon_e.last, mon_e.sw, mon_e.flag);
            end
        end
    end

    initial begin
        int  cnt, cyc;
        bit  ce, st;
        n_rst = 1'b0; start = 1'b0; n_columns = '0; n_rows = '0;
        serpentine = 1'b0; count_enable = 1'b0; flag_clear = 1'b0;
        model_reset();
        @(posedge clk); #1;
        exp_q.push_back(expect_now());
        n_rst = 1'b1;
        idle(1);

        // 3x2 frame, enable held high
        cycle(1, 3, 2, 0, 0, 0); run(6, 1); idle(2);
        // zero-width frame
        cycle(1, 0, 5, 0, 1, 0); run(3, 1);
        // 4x3 with serpentine requested
        cycle(1, 4, 3, 1, 0, 0); run(12, 1); idle(1);
        // flag_clear on the final edge, then one cycle later
        cycle(1, 2, 1, 0, 0, 0); cycle(0, 0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1); idle(1);
        // abort at (2,1) of 4x4 with a 2x2 restart
        cycle(1, 4, 4, 0, 0, 0); run(6, 1); cycle(1, 2, 2, 0, 1, 0); run(4, 1); idle(1);

        // 5x5 with random enables: count enables until the flag appears
        cycle(1, 5, 5, 0, 0, 0);
        cnt = 0; cyc = 0;
        while (!image_done_flag && cyc < 300) begin
            ce = ($urandom % 3) != 0;
            if (busy && ce) cnt++;
            cycle(0, 0, 0, 0, ce, 0);
            cyc++;
        end
        total++;
        if (cnt != 25 || image_done_flag !== 1'b1) begin
            bad++;
            $display("FAIL enable_count got %0d flag=%0b want 25 flag=1", cnt, image_done_flag);
        end
        idle(1);

        // single-column frame, maximum-size frame, restart from it
        cycle(1, 1, 3, 1, 0, 0); run(3, 1); idle(1);
        cycle(1, 65535, 65535, 1, 0, 0); run(40, 1);
        cycle(1, 3, 1, 0, 1, 0); run(3, 1); idle(1);
        cycle(1, 65535, 2, 1, 0, 0); run(3, 1);

        // asynchronous reset mid-frame
        @(negedge clk); #1;
        n_rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || col_count_out !== '0 || row_count_out !== '0 || last_pixel !== 1'b0 ||
            switch_rows !== 1'b0 || image_done_flag !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got busy=%0b col=%0d row=%0d last=%0b sw=%0b flag=%0b want all zero",
                     busy, col_count_out, row_count_out, last_pixel, switch_rows, image_done_flag);
        end
        model_reset();
        @(posedge clk); #1;
        exp_q.push_back(expect_now());
        n_rst = 1'b1;
        idle(1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            st = m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            cycle(st, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1'($urandom % 2),
                  ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        @(negedge clk); @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
